// File: rtl/fsmserial_tx.sv
// Serial frame transmitter: start bit, 8 data bits LSB first, optional odd parity, stop bit.
// Define FSMSERIAL_TX_PARITY_EN to compile in the odd-parity bit (11-bit frames instead of 10).
module fsmserial_tx (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out,
  output logic       done,
  output logic       busy
);

  typedef enum logic [2:0] {
    Idle,
    Start,
    Data,
`ifdef FSMSERIAL_TX_PARITY_EN
    Parity,
`endif
    Stop
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       holdValid_q, holdValid_d;
`ifdef FSMSERIAL_TX_PARITY_EN
  logic       par_q, par_d;
`endif
  logic       out_q, out_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       accept;
  logic       load;

  assign accept = in_valid & ~holdValid_q;

  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    holdValid_d = holdValid_q;
`ifdef FSMSERIAL_TX_PARITY_EN
    par_d       = par_q;
`endif
    load        = 1'b0;

    if (accept) begin
      hold_d      = in_byte;
      holdValid_d = 1'b1;
    end

    case (state_q)
      Idle: begin
        if (holdValid_q) load = 1'b1;
      end
      Start: begin
        state_d  = Data;
        bitCnt_d = 3'd0;
`ifdef FSMSERIAL_TX_PARITY_EN
        par_d    = 1'b1;
`endif
      end
      Data: begin
        shift_d  = shift_q >> 1;
        bitCnt_d = bitCnt_q + 3'd1;
`ifdef FSMSERIAL_TX_PARITY_EN
        par_d    = par_q ^ shift_q[0];
        if (bitCnt_q == 3'd7) state_d = Parity;
`else
        if (bitCnt_q == 3'd7) state_d = Stop;
`endif
      end
`ifdef FSMSERIAL_TX_PARITY_EN
      Parity: begin
        state_d = Stop;
      end
`endif
      Stop: begin
        if (holdValid_q) load = 1'b1;
        else             state_d = Idle;
      end
      default: begin
        state_d = Idle;
      end
    endcase

    // Loading only happens while the holding register is full, so it never collides with an accept.
    if (load) begin
      state_d     = Start;
      shift_d     = hold_q;
      holdValid_d = 1'b0;
    end

    case (state_d)
      Start:   out_d = 1'b0;
      Data:    out_d = shift_d[0];
`ifdef FSMSERIAL_TX_PARITY_EN
      Parity:  out_d = par_d;
`endif
      default: out_d = 1'b1;
    endcase
    done_d = (state_d == Stop);
    busy_d = (state_d != Idle) | holdValid_d;
  end

  // Outputs are decoded from next-state values so they register alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= Idle;
      bitCnt_q    <= 3'd0;
      shift_q     <= 8'd0;
      hold_q      <= 8'd0;
      holdValid_q <= 1'b0;
`ifdef FSMSERIAL_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
      out_q       <= 1'b1;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      holdValid_q <= holdValid_d;
`ifdef FSMSERIAL_TX_PARITY_EN
      par_q       <= par_d;
`endif
      out_q       <= out_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready = ~holdValid_q;
  assign out      = out_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_fsmserial_tx.sv
// Self-checking bench for fsmserial_tx: directed scenarios plus random traffic against a bit-queue model.
// Honours FSMSERIAL_TX_PARITY_EN the same way as the design.
module tb_fsmserial_tx;

  logic       clk;
  logic       reset;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic       out;
  logic       done;
  logic       busy;

  int compared;
  int mismatched;

  // Reference model: the line is a queue of bits still to send; head is the bit currently on the wire.
  bit         bitQ[$];
  bit         mHoldValid;
  logic [7:0] mHold;
  bit         accepted;

  fsmserial_tx dut (
    .clk      (clk),
    .reset    (reset),
    .in_byte  (in_byte),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .done     (done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void pushFrame(input logic [7:0] b);
    bitQ.push_back(1'b0);
    for (int i = 0; i < 8; i++) bitQ.push_back(b[i]);
`ifdef FSMSERIAL_TX_PARITY_EN
    bitQ.push_back(~^b);
`endif
    bitQ.push_back(1'b1);
  endfunction

  task automatic check(input string tag, input logic observed, input logic expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkOutput();
    bit expOut;
    expOut = (bitQ.size() == 0) ? 1'b1 : bitQ[0];
    check("out", out, expOut);
    check("done", done, bitQ.size() == 1);
    check("in_ready", in_ready, !mHoldValid);
    check("busy", busy, (bitQ.size() != 0) || mHoldValid);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] b, input logic r);
    bit oldHoldValid;
    in_valid = v;
    in_byte  = b;
    reset    = r;
    @(posedge clk);
    accepted = 1'b0;
    if (r) begin
      bitQ.delete();
      mHoldValid = 1'b0;
      mHold      = 8'd0;
    end else begin
      oldHoldValid = mHoldValid;
      if (bitQ.size() > 0) void'(bitQ.pop_front());
      if (bitQ.size() == 0 && oldHoldValid) begin
        pushFrame(mHold);
        mHoldValid = 1'b0;
      end
      if (v && !oldHoldValid) begin
        mHold      = b;
        mHoldValid = 1'b1;
        accepted   = 1'b1;
      end
    end
    #1;
    checkOutput();
  endtask

  initial begin
    logic [10:0] cap;
    logic [7:0]  b2b[3];
    logic [7:0]  bp[3];
    int          doneCnt;
    int          idx;

    compared   = 0;
    mismatched = 0;
    mHoldValid = 1'b0;
    mHold      = 8'd0;
    in_valid   = 1'b0;
    in_byte    = 8'd0;
    reset      = 1'b1;

    $display("[TB] reset and idle");
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'hEE, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] single byte 0xA5");
    applyStimulus(1'b1, 8'hA5, 1'b0);
    doneCnt = 0;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      cap[i] = out;
      if (done) doneCnt++;
    end
    // 0,1,0,1,0,0,1,0,1,1 then either parity 1 or idle 1: identical 11-cycle line either way.
    compared++;
    assert (cap === 11'h74A)
    else begin
      mismatched++;
      $error("[TB] FAIL a5_frame: observed %h expected %h", cap, 11'h74A);
    end
    compared++;
    assert (doneCnt == 1)
    else begin
      mismatched++;
      $error("[TB] FAIL a5_done_count: observed %0d expected 1", doneCnt);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] single byte 0x01");
    applyStimulus(1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] back-to-back");
    b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h3C;
    idx = 0;
    doneCnt = 0;
    for (int i = 0; i < 45; i++) begin
      applyStimulus(idx < 3, b2b[idx % 3], 1'b0);
      if (accepted) idx++;
      if (done) doneCnt++;
    end
    compared++;
    assert (doneCnt == 3)
    else begin
      mismatched++;
      $error("[TB] FAIL b2b_done_count: observed %0d expected 3", doneCnt);
    end

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 8'h55, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h0F, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b1);
    doneCnt = 0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      if (done) doneCnt++;
    end
    compared++;
    assert (doneCnt == 0)
    else begin
      mismatched++;
      $error("[TB] FAIL abort_done_count: observed %0d expected 0", doneCnt);
    end

    $display("[TB] backpressure");
    bp[0] = 8'h11; bp[1] = 8'h22; bp[2] = 8'h33;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, bp[i], 1'b0);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(1, 0) == 1, 8'($urandom), $urandom_range(249, 0) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
